// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with a frame-synchronous
// double buffer, per-digit enable/decimal point and leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] value_in,
  input  logic [7:0]  digit_en_in,
  input  logic [7:0]  dp_in,
  input  logic        blank_lz_in,
  output logic [3:0]  hex,
  output logic [7:0]  anode,
  output logic        dp_n,
  output logic        frame_done,
  output logic        pending
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;

  logic [31:0] disp_val_q, disp_val_d;
  logic [7:0]  disp_en_q, disp_en_d;
  logic [7:0]  disp_dp_q, disp_dp_d;
  logic        disp_blank_q, disp_blank_d;

  logic [31:0] pend_val_q, pend_val_d;
  logic [7:0]  pend_en_q, pend_en_d;
  logic [7:0]  pend_dp_q, pend_dp_d;
  logic        pend_blank_q, pend_blank_d;
  logic        pending_q, pending_d;

  logic [7:0]  anode_q, anode_d;
  logic [3:0]  hex_q, hex_d;
  logic        dp_n_q, dp_n_d;
  logic        frame_done_q, frame_done_d;

  logic        tick;
  logic        boundary;
  logic [7:0]  nz_from;
  logic [7:0]  digit_on;
  logic        nz_acc;

  always_comb begin
    tick     = (div_q == DIV_LAST);
    boundary = tick && (idx_q == 3'd7);
    div_d    = tick ? '0 : div_q + 1'b1;
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
  end

  // The boundary moves the buffer contents as they stood before this edge,
  // so a coincident load survives in the buffer for the following frame.
  always_comb begin
    disp_val_d   = disp_val_q;
    disp_en_d    = disp_en_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    pend_val_d   = pend_val_q;
    pend_en_d    = pend_en_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pending_d    = pending_q;

    if (boundary && pending_q) begin
      disp_val_d   = pend_val_q;
      disp_en_d    = pend_en_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
    end
    if (boundary) begin
      pending_d = 1'b0;
    end
    if (load) begin
      pend_val_d   = value_in;
      pend_en_d    = digit_en_in;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_lz_in;
      pending_d    = 1'b1;
    end
    frame_done_d = boundary;
  end

  // nz_from[i] is set when any nibble at position i or above is non-zero.
  always_comb begin
    nz_from  = '0;
    digit_on = '0;
    nz_acc   = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      nz_acc     = nz_acc | (|disp_val_q[4*i +: 4]);
      nz_from[i] = nz_acc;
    end
    for (int i = 0; i < 8; i++) begin
      digit_on[i] = disp_en_q[i] && (!disp_blank_q || (i == 0) || nz_from[i]);
    end
  end

  always_comb begin
    anode_d = 8'hFF;
    hex_d   = 4'h0;
    dp_n_d  = 1'b1;
    if (digit_on[idx_q]) begin
      anode_d = ~(8'b1 << idx_q);
      hex_d   = disp_val_q[{idx_q, 2'b00} +: 4];
      dp_n_d  = ~disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      disp_val_q   <= '0;
      disp_en_q    <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= 1'b0;
      pend_val_q   <= '0;
      pend_en_q    <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= 1'b0;
      pending_q    <= 1'b0;
      anode_q      <= 8'hFF;
      hex_q        <= 4'h0;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_en_q    <= disp_en_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      pend_val_q   <= pend_val_d;
      pend_en_q    <= pend_en_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pending_q    <= pending_d;
      anode_q      <= anode_d;
      hex_q        <= hex_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anode      = anode_q;
  assign hex        = hex_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with REFRESH_DIV = 4 (32-cycle frames);
// expected scan patterns are hand-written per digit, digit 7 in the top bits.
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        clk_en;
  logic        reset_n;
  logic        load;
  logic [31:0] value_in;
  logic [7:0]  digit_en_in;
  logic [7:0]  dp_in;
  logic        blank_lz_in;
  logic [3:0]  hex;
  logic [7:0]  anode;
  logic        dp_n;
  logic        frame_done;
  logic        pending;

  int n_tot = 0;
  int n_bad = 0;

  seg7_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .value_in    (value_in),
    .digit_en_in (digit_en_in),
    .dp_in       (dp_in),
    .blank_lz_in (blank_lz_in),
    .hex         (hex),
    .anode       (anode),
    .dp_n        (dp_n),
    .frame_done  (frame_done),
    .pending     (pending)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      clk = clk_en ? ~clk : 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] v, input logic [7:0] en,
                       input logic [7:0] dp, input logic bl);
    value_in    = v;
    digit_en_in = en;
    dp_in       = dp;
    blank_lz_in = bl;
    load        = 1'b1;
    step(1);
    load        = 1'b0;
  endtask

  // Called at the negedge right after a boundary edge; samples all 32 cycles of
  // the frame and finishes on the negedge right after the next boundary.
  task automatic scan_frame(input string tag, input logic [63:0] an,
                            input logic [31:0] hx, input logic [7:0] dpn);
    logic fd_e;
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < 4; c++) begin
        step(1);
        fd_e = (d == 7) && (c == 3);
        chk(tag, {18'd0, anode, hex, dp_n, frame_done},
                 {18'd0, an[8*d +: 8], hx[4*d +: 4], dpn[d], fd_e});
      end
    end
  endtask

  task automatic load_frame(input logic [31:0] v, input logic [7:0] en,
                            input logic [7:0] dp, input logic bl);
    drive(v, en, dp, bl);
    chk("pend_set", {31'd0, pending}, 32'd1);
    step(31);
    chk("fd_boundary", {31'd0, frame_done}, 32'd1);
    chk("pend_clr", {31'd0, pending}, 32'd0);
  endtask

  initial begin
    clk_en      = 1'b0;
    reset_n     = 1'b1;
    load        = 1'b0;
    value_in    = '0;
    digit_en_in = '0;
    dp_in       = '0;
    blank_lz_in = 1'b0;

    #5 reset_n = 1'b0;
    #5;
    chk("rst_anode", {24'd0, anode}, 32'hFF);
    chk("rst_dp_n", {31'd0, dp_n}, 32'd1);
    chk("rst_pending", {31'd0, pending}, 32'd0);
    chk("rst_hex", {28'd0, hex}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    #6 reset_n = 1'b1;
    #1 clk_en = 1'b1;

    for (int i = 0; i < 64; i++) begin
      step(1);
      chk("dark_anode", {24'd0, anode}, 32'hFF);
    end
    chk("fd_second_frame", {31'd0, frame_done}, 32'd1);

    load_frame(32'h1234ABCD, 8'hFF, 8'h00, 1'b0);
    scan_frame("basic", 64'h7FBFDFEFF7FBFDFE, 32'h1234ABCD, 8'hFF);
    scan_frame("basic_rpt", 64'h7FBFDFEFF7FBFDFE, 32'h1234ABCD, 8'hFF);

    load_frame(32'h00000050, 8'hFF, 8'h00, 1'b1);
    scan_frame("blank_50", 64'hFFFFFFFFFFFFFDFE, 32'h00000050, 8'hFF);

    load_frame(32'h00A00B00, 8'hFF, 8'h00, 1'b1);
    scan_frame("blank_inner", 64'hFFFFDFEFF7FBFDFE, 32'h00A00B00, 8'hFF);

    load_frame(32'h00000000, 8'hFF, 8'h00, 1'b1);
    scan_frame("blank_zero", 64'hFFFFFFFFFFFFFFFE, 32'h00000000, 8'hFF);

    load_frame(32'h87654321, 8'h0F, 8'h24, 1'b0);
    scan_frame("mask_dp", 64'hFFFFFFFFF7FBFDFE, 32'h00004321, 8'hFB);

    // Two loads inside one frame: only the second may appear.
    drive(32'h11111111, 8'hFF, 8'h00, 1'b0);
    drive(32'hFEDC0987, 8'hFF, 8'h01, 1'b0);
    chk("dbl_pend", {31'd0, pending}, 32'd1);
    step(30);
    chk("dbl_fd", {31'd0, frame_done}, 32'd1);
    chk("dbl_pend_clr", {31'd0, pending}, 32'd0);
    scan_frame("dbl_last", 64'h7FBFDFEFF7FBFDFE, 32'hFEDC0987, 8'hFE);

    // Load landing exactly on the boundary edge, nothing pending before.
    step(31);
    chk("coin_pre_pend", {31'd0, pending}, 32'd0);
    drive(32'h000000C0, 8'hFF, 8'h00, 1'b1);
    chk("coin_fd", {31'd0, frame_done}, 32'd1);
    chk("coin_pend_kept", {31'd0, pending}, 32'd1);
    scan_frame("coin_old", 64'h7FBFDFEFF7FBFDFE, 32'hFEDC0987, 8'hFE);
    chk("coin_pend_clr", {31'd0, pending}, 32'd0);
    scan_frame("coin_new", 64'hFFFFFFFFFFFFFDFE, 32'h000000C0, 8'hFF);

    // Boundary-coincident load with an earlier load already pending.
    drive(32'h5A5A5A5A, 8'hAA, 8'hFF, 1'b0);
    step(30);
    drive(32'h1234ABCD, 8'hFF, 8'h00, 1'b1);
    chk("coin2_fd", {31'd0, frame_done}, 32'd1);
    chk("coin2_pend", {31'd0, pending}, 32'd1);
    scan_frame("coin2_prev", 64'h7FFFDFFFF7FFFDFF, 32'h50505050, 8'h55);
    chk("coin2_pend_clr", {31'd0, pending}, 32'd0);
    scan_frame("coin2_new", 64'h7FBFDFEFF7FBFDFE, 32'h1234ABCD, 8'hFF);

    // Reset during the digit 5 slot with a load pending.
    drive(32'h99999999, 8'hFF, 8'h00, 1'b0);
    chk("mid_pend", {31'd0, pending}, 32'd1);
    step(21);
    chk("mid_digit5", {20'd0, anode, hex}, {20'd0, 8'hDF, 4'h3});
    reset_n = 1'b0;
    #1;
    chk("mid_rst_anode", {24'd0, anode}, 32'hFF);
    chk("mid_rst_hex", {28'd0, hex}, 32'd0);
    chk("mid_rst_dp_n", {31'd0, dp_n}, 32'd1);
    chk("mid_rst_pend", {31'd0, pending}, 32'd0);
    chk("mid_rst_fd", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step(1);
      chk("post_rst_dark", {24'd0, anode}, 32'hFF);
    end
    chk("post_rst_pend", {31'd0, pending}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
